shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 114 +++++++++++
 tb/tb_shift_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - 8-bit multi-cycle shifter; optional rotate build via SHIFT_ROTATE_EN
module shift_bit1 (
    input  logic [7:0] din,
    input  logic       dir,
    input  logic       fill_en,
    output logic [7:0] dout,
    output logic       shift_out
);
    always_comb begin
        if (dir) begin
            shift_out = din[7];
            dout      = {din[6:0], fill_en & din[7]};
        end else begin
            shift_out = din[0];
            dout      = {fill_en & din[0], din[7:1]};
        end
    end
endmodule

module shift_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic [2:0] amount,
    input  logic [7:0] data_in,
`ifdef SHIFT_ROTATE_EN
    input  logic       rot,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, next_state;
    logic [7:0] acc;
    logic [2:0] cnt;
    logic       dir_q;
    logic       rot_q;
    logic       carry_q;
    logic       rot_in;
    logic [7:0] sh_data;
    logic       sh_out;

`ifdef SHIFT_ROTATE_EN
    assign rot_in = rot;
`else
    assign rot_in = 1'b0;
`endif

    shift_bit1 u_shift_bit1 (
        .din       (acc),
        .dir       (dir_q),
        .fill_en   (rot_q),
        .dout      (sh_data),
        .shift_out (sh_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 8'h00;
            cnt     <= 3'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= data_in;
                        dir_q   <= dir;
                        rot_q   <= rot_in;
                        cnt     <= amount;
                        carry_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc     <= sh_data;
                    carry_q <= sh_out;
                    cnt     <= cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // A zero count skips SHIFT so done follows the sampling edge directly
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (amount == 3'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd1) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign result = acc;
    assign carry  = carry_q;
endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - randomized + directed checks of shift_unit against a reference model
module tb_shift_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [2:0] amount;
    logic [7:0] data_in;
    logic       rot;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    shift_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .amount  (amount),
        .data_in (data_in),
`ifdef SHIFT_ROTATE_EN
        .rot     (rot),
`endif
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    // {carry, result} after k single-bit steps applied to d
    function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic dr,
                                             input logic rt, input int k);
        logic [15:0] w;
        logic [7:0]  r;
        logic        c;
        if (k == 0) return {1'b0, d};
        w = {d, d};
        if (dr) begin
            r = rt ? 8'(w >> (8 - k)) : 8'(d << k);
            c = d[8 - k];
        end else begin
            r = rt ? 8'(w >> k) : 8'(d >> k);
            c = d[k - 1];
        end
        return {c, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: edges elapsed since acceptance decide busy/done/result
    bit         m_active = 1'b0;
    int         m_e = 0;
    int         m_n = 0;
    logic [7:0] m_d = 8'h00;
    logic       m_dir = 1'b0;
    logic       m_rot = 1'b0;
    logic [7:0] m_hres = 8'h00;
    logic       m_hcar = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_hres   = 8'h00;
            m_hcar   = 1'b0;
        end else if (m_active) begin
            if (m_e == m_n) begin
                m_active         = 1'b0;
                {m_hcar, m_hres} = ref_shift(m_d, m_dir, m_rot, m_n);
            end else begin
                m_e++;
            end
        end else if (start) begin
            m_d      = data_in;
            m_dir    = dir;
`ifdef SHIFT_ROTATE_EN
            m_rot    = rot;
`else
            m_rot    = 1'b0;
`endif
            m_n      = int'(amount);
            m_e      = 0;
            m_active = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_rc;
        if (mon_en) begin
            exp_rc = m_active ? ref_shift(m_d, m_dir, m_rot, m_e) : {m_hcar, m_hres};
            check("mon_busy",   32'(busy),   32'(m_active));
            check("mon_done",   32'(done),   32'(m_active && (m_e == m_n)));
            check("mon_result", 32'(result), 32'(exp_rc[7:0]));
            check("mon_carry",  32'(carry),  32'(exp_rc[8]));
        end
    end

    task automatic run_op(input logic [7:0] d, input logic dr, input logic rt, input logic [2:0] n,
                          input logic [7:0] er, input logic ec, input string name);
        int lat;
        int nb;
        logic [7:0] dres;
        logic       dcar;
        @(negedge clk);
        start = 1'b1; data_in = d; dir = dr; amount = n; rot = rt;
        @(negedge clk);
        start = 1'b0; data_in = 8'($urandom); dir = 1'($urandom); amount = 3'($urandom);
        rot = 1'($urandom);
        lat = -1; nb = 0; dres = 8'h00; dcar = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nb++;
            if (done && lat < 0) begin
                lat = i; dres = result; dcar = carry;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'(n));
        check({name, "_busy_cycles"}, 32'(nb), 32'(n) + 1);
        check({name, "_result"}, 32'(dres), 32'(er));
        check({name, "_carry"}, 32'(dcar), 32'(ec));
        check({name, "_hold"}, 32'({carry, result}), 32'({ec, er}));
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; dir = 1'b0; amount = 3'd0; data_in = 8'h00; rot = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry",  32'(carry),  32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        check("model_right3", 32'(ref_shift(8'hB5, 1'b0, 1'b0, 3)), 32'h116);
        check("model_left1",  32'(ref_shift(8'h81, 1'b1, 1'b0, 1)), 32'h102);
        check("model_left7",  32'(ref_shift(8'h01, 1'b1, 1'b0, 7)), 32'h080);

        run_op(8'h81, 1'b1, 1'b0, 3'd1, 8'h02, 1'b1, "left1");
        run_op(8'hB5, 1'b0, 1'b0, 3'd3, 8'h16, 1'b1, "right3");
        run_op(8'h5A, 1'b1, 1'b0, 3'd0, 8'h5A, 1'b0, "zero");
        run_op(8'hFF, 1'b0, 1'b0, 3'd7, 8'h01, 1'b1, "right7");
`ifdef SHIFT_ROTATE_EN
        run_op(8'h81, 1'b1, 1'b1, 3'd1, 8'h03, 1'b1, "rot_left1");
        run_op(8'h81, 1'b1, 1'b1, 3'd4, 8'h18, 1'b0, "rot_left4");
`endif

        // Second start mid-SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; data_in = 8'h01; dir = 1'b1; amount = 3'd7; rot = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            start = (i >= 2 && i < 5);
            if (start) begin data_in = 8'hFF; dir = 1'b0; amount = 3'd2; end
            if (done) ndone++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_dones",  32'(ndone),  32'd1);
        check("busy_start_result", 32'(result), 32'h80);
        check("busy_start_carry",  32'(carry),  32'd0);

        // Start coincident with done is not accepted
        @(negedge clk);
        start = 1'b1; data_in = 8'h81; dir = 1'b1; amount = 3'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        check("done_seen", 32'(done), 32'd1);
        start = 1'b1; data_in = 8'hFF; amount = 3'd3;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_busy",   32'(busy),   32'd0);
        check("start_in_done_result", 32'(result), 32'h04);

        // Reset on the 2nd SHIFT edge abandons the operation
        @(negedge clk);
        start = 1'b1; data_in = 8'hC3; dir = 1'b0; amount = 3'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_carry",  32'(carry),  32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        // Randomized traffic, checked every cycle by the monitor
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 2) == 0);
            dir     = 1'($urandom);
            amount  = 3'($urandom);
            data_in = 8'($urandom);
            rot     = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
